// File: rtl/copi_sched_pkg.sv
// copi_sched_pkg: shared types and defaults for the COPI command scheduler
package copi_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CAL} state_t;
  typedef enum logic [1:0] {SRC_BASE, SRC_QUEUE, SRC_CAL} src_t;
  localparam int DEF_NUM_SLOTS = 35;
  localparam logic [15:0] DEF_CAL_CMD = 16'h5500;
  localparam logic [15:0] DEF_DUMMY_CMD = 16'hE800;
endpackage

// File: rtl/copi_cmd_fifo.sv
// copi_cmd_fifo: one-shot command queue with flush and push-while-full-on-pop
module copi_cmd_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    mem_d = mem_q;
    mem_d[wr_q] = (do_push && !flush) ? din : mem_q[wr_q];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/copi_cmd_scheduler.sv
// copi_cmd_scheduler: per-slot COPI word sequencer (base program, one-shot queue, calibration)
module copi_cmd_scheduler
  import copi_sched_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int AUX_FIRST = 32,
  parameter int QDEPTH = 8,
  parameter int CAL_FRAMES = 9,
  parameter logic [15:0] CAL_CMD = DEF_CAL_CMD,
  parameter logic [15:0] DUMMY_CMD = DEF_DUMMY_CMD,
  localparam int QCW = $clog2(QDEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    slot_adv,
  input  logic                    frame_wrap,
  input  logic [NUM_SLOTS*16-1:0] base_words,
  input  logic                    cmd_valid,
  input  logic [15:0]             cmd_data,
  output logic                    cmd_ready,
  input  logic                    queue_flush,
  input  logic                    cal_req,
  output logic [15:0]             copi_word,
  output logic [1:0]              word_src,
  output logic [5:0]              slot_idx,
  output logic [QCW-1:0]          queue_count,
  output logic                    cal_busy,
  output logic                    slot_err
);
  localparam int FCW = $clog2(CAL_FRAMES + 1);
  state_t state_q, state_d;
  src_t src_q, src_d;
  logic [NUM_SLOTS-1:0][15:0] shadow_q, shadow_d;
  logic [5:0] slot_q, slot_d, nxt, idx;
  logic [15:0] word_q, word_d, head, cal_word;
  logic [FCW-1:0] cal_cnt_q, cal_cnt_d;
  logic cal_busy_q, cal_busy_d, err_q, err_d;
  logic active, last, aux, cal_last, upd, pop, push, full, empty;
  always_comb begin
    active = state_q != IDLE;
    last = slot_q == 6'(NUM_SLOTS - 1);
    nxt = (frame_wrap || last) ? 6'd0 : slot_q + 6'd1;
    cal_last = cal_cnt_q == FCW'(CAL_FRAMES - 1);
    shadow_d = (!active || frame_wrap) ? base_words : shadow_q;
    state_d = !frame_wrap ? state_q : !run ? IDLE : state_q == IDLE ? RUN :
              state_q == RUN ? (cal_busy_q ? CAL : RUN) : (cal_last ? RUN : CAL);
    cal_cnt_d = state_q != CAL ? '0 : frame_wrap ? cal_cnt_q + FCW'(1) : cal_cnt_q;
    cal_busy_d = (frame_wrap && (!run || (state_q == CAL && cal_last))) ? 1'b0 : cal_busy_q | cal_req;
    slot_d = !active ? 6'd0 : (slot_adv || frame_wrap) ? nxt : slot_q;
    err_d = err_q | (active && (frame_wrap ? !last : slot_adv && last));
    upd = state_d == IDLE || slot_adv || frame_wrap;
    idx = state_d == IDLE ? 6'd0 : nxt;
    aux = idx >= 6'(AUX_FIRST);
    pop = state_q == RUN && slot_adv && !frame_wrap && aux && !empty;
    cal_word = (idx == 6'(AUX_FIRST) && cal_cnt_q == '0) ? CAL_CMD : DUMMY_CMD;
    src_d = !upd ? src_q : !aux ? SRC_BASE : state_d == CAL ? SRC_CAL : pop ? SRC_QUEUE : SRC_BASE;
    word_d = !upd ? word_q : src_d == SRC_QUEUE ? head : src_d == SRC_CAL ? cal_word : shadow_d[idx];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q <= SRC_BASE;
      shadow_q <= '0;
      slot_q <= '0;
      word_q <= '0;
      cal_cnt_q <= '0;
      cal_busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      shadow_q <= shadow_d;
      slot_q <= slot_d;
      word_q <= word_d;
      cal_cnt_q <= cal_cnt_d;
      cal_busy_q <= cal_busy_d;
      err_q <= err_d;
    end
  end
  assign cmd_ready = !rst && (!full || pop);
  assign push = cmd_valid && cmd_ready;
  copi_cmd_fifo #(.W(16), .DEPTH(QDEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(queue_flush), .din(cmd_data),
    .dout(head), .count(queue_count), .full(full), .empty(empty)
  );
  assign copi_word = word_q;
  assign word_src = src_q;
  assign slot_idx = slot_q;
  assign cal_busy = cal_busy_q;
  assign slot_err = err_q;
endmodule

// File: doc/copi_cmd_scheduler.md
Name: copi_cmd_scheduler

Overview:
Sequences the 16-bit COPI command word fed to the serial engine for each of the 35 slots of a frame. The word comes from one of three sources: a static per-slot base program, a queue of one-shot commands injected by the PS into the auxiliary slots, or an autonomous calibration sequence. It sits between the AXI control registers and the serial/acquisition core. It tracks the core's slot timing through slot-advance and frame-wrap strobes and presents each slot's word before that slot begins.

Parameters:
NUM_SLOTS, 35, slots per frame.
AUX_FIRST, 32, first auxiliary slot; slots AUX_FIRST..NUM_SLOTS-1 are auxiliary.
QDEPTH, 8, one-shot command queue depth (power of 2).
CAL_FRAMES, 9, frames occupied by a calibration sequence.
CAL_CMD, 16'h5500, calibrate command.
DUMMY_CMD, 16'hE800, filler command issued during calibration.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
run  in  1  core transmission active; sampled only at frame_wrap
slot_adv  in  1  one-clk pulse on the edge where the core enters the next slot
frame_wrap  in  1  one-clk pulse coincident with slot_adv when the core wraps to slot 0
base_words  in  NUM_SLOTS*16  base program; slot s occupies bits [s*16 +: 16]
cmd_valid  in  1  one-shot command offered
cmd_data  in  16  one-shot command word
cmd_ready  out  1  queue can accept
queue_flush  in  1  discard all queued commands
cal_req  in  1  request a calibration sequence (pulse)
copi_word  out  16  word for the current slot; stable for the whole slot
word_src  out  2  source of copi_word: 0 base, 1 queue, 2 calibration
slot_idx  out  6  current slot index
queue_count  out  $clog2(QDEPTH+1)  number of queued commands
cal_busy  out  1  calibration pending or in progress
slot_err  out  1  sticky slot-alignment error

Behaviour:
- Reset (async, rst=1):
  - copi_word=0, word_src=0, slot_idx=0.
  - queue empty, queue_count=0, cmd_ready=0.
  - cal_busy=0, slot_err=0, state IDLE.
  - Shadow base program cleared to 0.
- Shadow program: base_words is copied to the shadow on every frame_wrap edge, and on every clock while in IDLE. Mid-frame writes never change the current frame.
- States:
  - IDLE: holds slot_idx=0 and copi_word=shadow[0], so slot 0 is valid before the first frame. IDLE->RUN on frame_wrap with run=1.
  - RUN: on each slot_adv, slot_idx advances (wrapping to 0 on frame_wrap), and copi_word/word_src are registered for the new slot on that same edge. Effective latency is 0 slots.
  - CAL: entered at frame_wrap when a calibration request is latched and run=1. Persists for exactly CAL_FRAMES frames, then returns to RUN.
  - Any state -> IDLE at a frame_wrap with run=0. This aborts CAL and clears cal_busy; the queue is kept.
- Word selection for new slot n:
  - Non-auxiliary slot: shadow[n], src 0.
  - Auxiliary slot in RUN: head of queue if non-empty (pop on that edge, src 1); otherwise shadow[n], src 0.
  - Auxiliary slot in CAL: slot AUX_FIRST of the first CAL frame issues CAL_CMD; every other auxiliary slot in CAL issues DUMMY_CMD. Both are src 2. The queue is not popped during CAL.
- Queue:
  - cmd_ready = !full && !rst.
  - A push occurs when cmd_valid && cmd_ready.
  - Simultaneous push and pop is legal when full, because the pop frees space: cmd_ready = !full || pop_this_cycle.
  - queue_flush empties the queue on the next edge and overrides a same-cycle push or pop. A flush that coincides with a pop still leaves the already-selected word issued.
- cal_req:
  - Latched; cal_busy rises on the next edge.
  - Ignored while cal_busy=1, with no queuing of a second request.
  - A request arriving in IDLE is held until RUN is entered, then CAL starts at the following frame_wrap.
- Errors (slot_err sets; cleared only by rst):
  - slot_adv at slot NUM_SLOTS-1 without frame_wrap: the slot counter wraps to 0 anyway.
  - frame_wrap while slot_idx != NUM_SLOTS-1: resync to slot 0.
- Strobes: slot_adv/frame_wrap in IDLE only cause the IDLE->RUN check. frame_wrap without slot_adv is treated as both.

Decomposition:
- Package copi_sched_pkg:
  - state enum {IDLE, RUN, CAL}.
  - word-source enum {SRC_BASE, SRC_QUEUE, SRC_CAL}.
  - NUM_SLOTS, CAL_CMD and DUMMY_CMD defaults.
- Sub-module copi_cmd_fifo: synchronous FIFO with async active-high reset, push/pop/flush, count, and simultaneous push/pop when full.

Test Plan:
- Base program: base[s]=16'h0100+s, run=1, two full frames -> copi_word sequence 0x0100..0x0122 per frame, word_src=0 throughout, slot_err=0.
- Queue injection: push 0x8001,0x8002,0x8003,0x8004 mid-frame -> slots 32,33,34 issue 0x8001..0x8003 (src 1); 0x8004 issues at slot 32 of the next frame; queue_count ends at 0.
- Full queue: push 9 words with no aux slot -> cmd_ready=0 after 8. At an aux slot with cmd_valid held -> pop and push on the same edge, count stays 8.
- Calibration: cal_req mid-frame -> cal_busy=1; next frame slot 32=0x5500, slots 33-34=0xE800; the following 8 frames have aux slots 0xE800; queued words are held until after frame 9; a second cal_req during CAL is ignored.
- Abort/reset: run=0 at frame_wrap during CAL -> IDLE, cal_busy=0, copi_word=base[0]. rst asserted mid-slot -> all outputs zero immediately (async).
- Misalignment: frame_wrap at slot 20 -> slot_idx=0, slot_err=1, sticky until rst.
